fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the program counter and the IF/ID pipeline register.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/ifid_reg.sv | 72 +++++++
 rtl/fetch_stage.sv | 176 +++++++++++++++++
 tb/tb_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t      : fetch FSM encoding (S_BOOT, S_RUN, S_HALT)
//   PC_W_DEFAULT       : default program-counter width in bits
//   NOP_INSTR_DEFAULT  : bubble instruction (addi x0,x0,0)
//   PC_STEP            : byte increment between sequential instructions
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    localparam int          PC_W_DEFAULT      = 9;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam int          PC_STEP           = 4;

endpackage

// File: rtl/ifid_reg.sv
// ----------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register holding the PC, instruction and valid flag of the
// instruction currently in decode.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   load_i     in   1      capture pc_i/instr_i as a real instruction
//   flush_i    in   1      insert a bubble (NOP, valid=0); cur_pc follows pc_i
//   pc_i       in   PC_W   PC of the instruction being fetched
//   instr_i    in   32     fetched instruction
//   cur_pc_o   out  PC_W   PC of instruction in decode
//   instr_o    out  32     instruction in decode
//   valid_o    out  1      1 = real instruction, 0 = bubble
//
// Neither load_i nor flush_i: all three fields hold (stall).
// flush_i has priority over load_i.
// ----------------------------------------------------------------------------
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int          PC_W      = PC_W_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic [PC_W-1:0] cur_pc_o,
    output logic [31:0]     instr_o,
    output logic            valid_o
);

    logic [PC_W-1:0] cur_pc_q, cur_pc_d;
    logic [31:0]     instr_q,  instr_d;
    logic            valid_q,  valid_d;

    always_comb begin
        cur_pc_d = cur_pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        if (flush_i) begin
            cur_pc_d = pc_i;
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
        end else if (load_i) begin
            cur_pc_d = pc_i;
            instr_d  = instr_i;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_pc_q <= '0;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
        end else begin
            cur_pc_q <= cur_pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    assign cur_pc_o = cur_pc_q;
    assign instr_o  = instr_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the program counter and the IF/ID register.
// Takes redirects from the branch unit, stalls from the hazard unit and a
// sticky halt request; drives the combinational-read instruction memory.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high
//   Stall        in   1      hold PC and IF/ID
//   PcSel        in   1      redirect taken
//   BrPC         in   32     redirect target (bits above PC_W and [1:0] ignored)
//   Halt         in   1      halt request; halt is sticky until reset
//   ImemAddr     out  PC_W   instruction memory address (= PC register)
//   ImemData     in   32     instruction memory data for ImemAddr, same cycle
//   Cur_PC       out  PC_W   IF/ID: PC of instruction in decode
//   Instr_ID     out  32     IF/ID: instruction in decode
//   Valid_ID     out  1      IF/ID: 1 = real instruction, 0 = bubble
//   Halted       out  1      1 while FSM is in S_HALT
//   FetchCnt     out  32     (FETCH_PERF_CNT_EN) real instructions loaded
//   FlushCnt     out  32     (FETCH_PERF_CNT_EN) S_RUN cycles with PcSel
//   StallCnt     out  32     (FETCH_PERF_CNT_EN) S_RUN cycles with Stall, no PcSel
//   dbg_state_o  out  2      current FSM state
//
// Configuration macro: FETCH_PERF_CNT_EN adds the three wrapping counters.
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          PC_W      = PC_W_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Halt,
    output logic [PC_W-1:0] ImemAddr,
    input  logic [31:0]     ImemData,
    output logic [PC_W-1:0] Cur_PC,
    output logic [31:0]     Instr_ID,
    output logic            Valid_ID,
    output logic            Halted,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     FetchCnt,
    output logic [31:0]     FlushCnt,
    output logic [31:0]     StallCnt,
`endif
    output fetch_state_t    dbg_state_o
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] br_target;
    logic            ifid_load;
    logic            ifid_flush;

    // Redirect target is truncated to the PC width and forced word aligned.
    assign br_target = BrPC[PC_W-1:0] & ~(PC_W'(3));

    // Bits of BrPC that never reach the PC.
    logic unused_brpc;
    assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

    // ------------------------------------------------------------------
    // FSM next-state, next-PC and IF/ID controls.
    // Priority inside S_RUN: Halt > PcSel > Stall > sequential.
    // A redirect flushes IF/ID even when Stall is also asserted.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            S_BOOT: begin
                // One boot bubble; the PC is not advanced here.
                state_d    = S_RUN;
                ifid_flush = 1'b1;
            end
            S_RUN: begin
                if (Halt) begin
                    state_d    = S_HALT;
                    ifid_flush = 1'b1;
                end else if (PcSel) begin
                    pc_d       = br_target;
                    ifid_flush = 1'b1;
                end else if (Stall) begin
                    // hold PC and IF/ID
                end else begin
                    pc_d      = pc_q + PC_W'(PC_STEP);
                    ifid_load = 1'b1;
                end
            end
            S_HALT: begin
                // Absorbing; only reset leaves. PC is held, so the flush
                // keeps Cur_PC at the halted PC.
                ifid_flush = 1'b1;
            end
            default: begin
                state_d    = S_BOOT;
                ifid_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ifid_reg #(
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk      (clk),
        .reset    (reset),
        .load_i   (ifid_load),
        .flush_i  (ifid_flush),
        .pc_i     (pc_q),
        .instr_i  (ImemData),
        .cur_pc_o (Cur_PC),
        .instr_o  (Instr_ID),
        .valid_o  (Valid_ID)
    );

    assign ImemAddr    = pc_q;
    // Derived from the state register, so it rises the cycle after Halt
    // is sampled in S_RUN.
    assign Halted      = (state_q == S_HALT);
    assign dbg_state_o = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (ifid_load) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (state_q == S_RUN && PcSel) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
        if (state_q == S_RUN && Stall && !PcSel) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign FetchCnt = fetch_cnt_q;
    assign FlushCnt = flush_cnt_q;
    assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. Instruction memory is a combinational model
// whose word at address a is {16'hC0DE, 7'b0, a}. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int          PC_W = 9;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic            clk;
    logic            reset;
    logic            Stall;
    logic            PcSel;
    logic [31:0]     BrPC;
    logic            Halt;
    logic [PC_W-1:0] ImemAddr;
    logic [31:0]     ImemData;
    logic [PC_W-1:0] Cur_PC;
    logic [31:0]     Instr_ID;
    logic            Valid_ID;
    logic            Halted;
    fetch_state_t    dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     FetchCnt;
    logic [31:0]     FlushCnt;
    logic [31:0]     StallCnt;
`endif

    int errors = 0;
    int checks = 0;

    fetch_stage #(.PC_W(PC_W), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .Stall       (Stall),
        .PcSel       (PcSel),
        .BrPC        (BrPC),
        .Halt        (Halt),
        .ImemAddr    (ImemAddr),
        .ImemData    (ImemData),
        .Cur_PC      (Cur_PC),
        .Instr_ID    (Instr_ID),
        .Valid_ID    (Valid_ID),
        .Halted      (Halted),
`ifdef FETCH_PERF_CNT_EN
        .FetchCnt    (FetchCnt),
        .FlushCnt    (FlushCnt),
        .StallCnt    (StallCnt),
`endif
        .dbg_state_o (dbg_state)
    );

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return {16'hC0DE, 7'b0, a};
    endfunction

    assign ImemData = mem_word(ImemAddr);

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Stall = 1'b0;
        PcSel = 1'b0;
        BrPC  = 32'h0;
        Halt  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Reset, leave boot, then run sequentially until ImemAddr == target.
    task automatic goto_pc(input int target);
        do_reset();
        tick();
        repeat (target / 4) tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (ImemAddr !== 9'h000) begin errors++; $display("FAIL reset_addr got=%h exp=%h", ImemAddr, 9'h000); end
        checks++; if (Cur_PC !== 9'h000) begin errors++; $display("FAIL reset_cur_pc got=%h exp=%h", Cur_PC, 9'h000); end
        checks++; if (Instr_ID !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", Instr_ID, NOP); end
        checks++; if (Valid_ID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", Valid_ID); end
        checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", Halted); end
        checks++; if (dbg_state !== S_BOOT) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_BOOT); end
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_sequential();
        logic [PC_W-1:0] exp_addr  [4];
        logic            exp_valid [4];
        exp_addr  = '{9'h000, 9'h000, 9'h004, 9'h008};
        exp_valid = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++; if (ImemAddr !== exp_addr[i]) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, ImemAddr, exp_addr[i]); end
            checks++; if (Valid_ID !== exp_valid[i]) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=%b", i, Valid_ID, exp_valid[i]); end
        end
        // Last sample: decode holds the instruction fetched from 0x004.
        checks++; if (Cur_PC !== 9'h004) begin errors++; $display("FAIL seq_cur_pc got=%h exp=%h", Cur_PC, 9'h004); end
        checks++; if (Instr_ID !== 32'hC0DE_0004) begin errors++; $display("FAIL seq_instr got=%h exp=%h", Instr_ID, 32'hC0DE_0004); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_redirect();
        goto_pc(32'h10);
        checks++; if (ImemAddr !== 9'h010) begin errors++; $display("FAIL redir_start got=%h exp=%h", ImemAddr, 9'h010); end
        PcSel = 1'b1;
        BrPC  = 32'h0000_0040;
        tick();
        PcSel = 1'b0;
        checks++; if (ImemAddr !== 9'h040) begin errors++; $display("FAIL redir_addr got=%h exp=%h", ImemAddr, 9'h040); end
        checks++; if (Valid_ID !== 1'b0) begin errors++; $display("FAIL redir_bubble got=%b exp=0", Valid_ID); end
        checks++; if (Instr_ID !== NOP) begin errors++; $display("FAIL redir_nop got=%h exp=%h", Instr_ID, NOP); end
        checks++; if (Cur_PC !== 9'h010) begin errors++; $display("FAIL redir_flush_pc got=%h exp=%h", Cur_PC, 9'h010); end
        tick();
        checks++; if (Valid_ID !== 1'b1) begin errors++; $display("FAIL redir_valid got=%b exp=1", Valid_ID); end
        checks++; if (Instr_ID !== 32'hC0DE_0040) begin errors++; $display("FAIL redir_instr got=%h exp=%h", Instr_ID, 32'hC0DE_0040); end
        checks++; if (Cur_PC !== 9'h040) begin errors++; $display("FAIL redir_cur_pc got=%h exp=%h", Cur_PC, 9'h040); end
        checks++; if (ImemAddr !== 9'h044) begin errors++; $display("FAIL redir_next got=%h exp=%h", ImemAddr, 9'h044); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        goto_pc(32'h8);
        PcSel = 1'b1;
        BrPC  = 32'h0000_0080;
        tick();
        checks++; if (ImemAddr !== 9'h080) begin errors++; $display("FAIL b2b_addr1 got=%h exp=%h", ImemAddr, 9'h080); end
        checks++; if (Valid_ID !== 1'b0) begin errors++; $display("FAIL b2b_valid1 got=%b exp=0", Valid_ID); end
        BrPC = 32'h0000_00C0;
        tick();
        PcSel = 1'b0;
        checks++; if (ImemAddr !== 9'h0C0) begin errors++; $display("FAIL b2b_addr2 got=%h exp=%h", ImemAddr, 9'h0C0); end
        checks++; if (Valid_ID !== 1'b0) begin errors++; $display("FAIL b2b_valid2 got=%b exp=0", Valid_ID); end
        tick();
        checks++; if (Instr_ID !== 32'hC0DE_00C0) begin errors++; $display("FAIL b2b_instr got=%h exp=%h", Instr_ID, 32'hC0DE_00C0); end
        checks++; if (Valid_ID !== 1'b1) begin errors++; $display("FAIL b2b_valid3 got=%b exp=1", Valid_ID); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        goto_pc(32'h8);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ImemAddr !== 9'h008) begin errors++; $display("FAIL stall_addr[%0d] got=%h exp=%h", i, ImemAddr, 9'h008); end
            checks++; if (Cur_PC !== 9'h004) begin errors++; $display("FAIL stall_cur_pc[%0d] got=%h exp=%h", i, Cur_PC, 9'h004); end
            checks++; if (Instr_ID !== 32'hC0DE_0004) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, Instr_ID, 32'hC0DE_0004); end
            checks++; if (Valid_ID !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, Valid_ID); end
        end
        // Redirect with Stall still high: redirect wins.
        PcSel = 1'b1;
        BrPC  = 32'h0000_0100;
        tick();
        PcSel = 1'b0;
        Stall = 1'b0;
        checks++; if (ImemAddr !== 9'h100) begin errors++; $display("FAIL stall_redir_addr got=%h exp=%h", ImemAddr, 9'h100); end
        checks++; if (Valid_ID !== 1'b0) begin errors++; $display("FAIL stall_redir_bubble got=%b exp=0", Valid_ID); end
        tick();
        checks++; if (Instr_ID !== 32'hC0DE_0100) begin errors++; $display("FAIL stall_redir_instr got=%h exp=%h", Instr_ID, 32'hC0DE_0100); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap_and_mask();
        goto_pc(32'h1FC);
        checks++; if (ImemAddr !== 9'h1FC) begin errors++; $display("FAIL wrap_start got=%h exp=%h", ImemAddr, 9'h1FC); end
        tick();
        checks++; if (ImemAddr !== 9'h000) begin errors++; $display("FAIL wrap_addr got=%h exp=%h", ImemAddr, 9'h000); end
        checks++; if (Cur_PC !== 9'h1FC) begin errors++; $display("FAIL wrap_cur_pc got=%h exp=%h", Cur_PC, 9'h1FC); end
        checks++; if (Instr_ID !== 32'hC0DE_01FC) begin errors++; $display("FAIL wrap_instr got=%h exp=%h", Instr_ID, 32'hC0DE_01FC); end
        PcSel = 1'b1;
        BrPC  = 32'h0000_0243;
        tick();
        checks++; if (ImemAddr !== 9'h040) begin errors++; $display("FAIL mask_addr got=%h exp=%h", ImemAddr, 9'h040); end
        BrPC = 32'hFFFF_FE86;
        tick();
        PcSel = 1'b0;
        checks++; if (ImemAddr !== 9'h084) begin errors++; $display("FAIL mask_addr_hi got=%h exp=%h", ImemAddr, 9'h084); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_halt();
        goto_pc(32'h20);
        Halt = 1'b1;
        checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL halt_pre got=%b exp=0", Halted); end
        tick();
        Halt = 1'b0;
        checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_asserted got=%b exp=1", Halted); end
        checks++; if (ImemAddr !== 9'h020) begin errors++; $display("FAIL halt_addr got=%h exp=%h", ImemAddr, 9'h020); end
        checks++; if (Valid_ID !== 1'b0) begin errors++; $display("FAIL halt_valid got=%b exp=0", Valid_ID); end
        checks++; if (Instr_ID !== NOP) begin errors++; $display("FAIL halt_instr got=%h exp=%h", Instr_ID, NOP); end
        // Sticky: other requests are ignored while halted.
        PcSel = 1'b1;
        BrPC  = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_sticky[%0d] got=%b exp=1", i, Halted); end
            checks++; if (ImemAddr !== 9'h020) begin errors++; $display("FAIL halt_hold[%0d] got=%h exp=%h", i, ImemAddr, 9'h020); end
            checks++; if (Valid_ID !== 1'b0) begin errors++; $display("FAIL halt_bubble[%0d] got=%b exp=0", i, Valid_ID); end
        end
        PcSel = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midway();
        // Reset during a stall.
        goto_pc(32'h8);
        Stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        Stall = 1'b0;
        checks++; if (ImemAddr !== 9'h000) begin errors++; $display("FAIL rst_stall_addr got=%h exp=%h", ImemAddr, 9'h000); end
        checks++; if (Cur_PC !== 9'h000) begin errors++; $display("FAIL rst_stall_cur_pc got=%h exp=%h", Cur_PC, 9'h000); end
        checks++; if (Instr_ID !== NOP) begin errors++; $display("FAIL rst_stall_instr got=%h exp=%h", Instr_ID, NOP); end
        checks++; if (Valid_ID !== 1'b0) begin errors++; $display("FAIL rst_stall_valid got=%b exp=0", Valid_ID); end
        // Reset while halted.
        goto_pc(32'h20);
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL rst_halt_halted got=%b exp=0", Halted); end
        checks++; if (ImemAddr !== 9'h000) begin errors++; $display("FAIL rst_halt_addr got=%h exp=%h", ImemAddr, 9'h000); end
        checks++; if (Cur_PC !== 9'h000) begin errors++; $display("FAIL rst_halt_cur_pc got=%h exp=%h", Cur_PC, 9'h000); end
        checks++; if (dbg_state !== S_BOOT) begin errors++; $display("FAIL rst_halt_state got=%0d exp=%0d", dbg_state, S_BOOT); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (FetchCnt !== 32'd0) begin errors++; $display("FAIL rst_fetch_cnt got=%0d exp=0", FetchCnt); end
        checks++; if (FlushCnt !== 32'd0) begin errors++; $display("FAIL rst_flush_cnt got=%0d exp=0", FlushCnt); end
        checks++; if (StallCnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", StallCnt); end
`endif
        // Restart after reset: boot bubble then sequential fetch again.
        tick();
        tick();
        checks++; if (Valid_ID !== 1'b1) begin errors++; $display("FAIL rst_restart_valid got=%b exp=1", Valid_ID); end
        checks++; if (Instr_ID !== 32'hC0DE_0000) begin errors++; $display("FAIL rst_restart_instr got=%h exp=%h", Instr_ID, 32'hC0DE_0000); end
    endtask

    // ------------------------------------------------------------------
    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_sequential();
        test_redirect();
        test_back_to_back();
        test_stall();
        test_wrap_and_mask();
        test_halt();
        test_reset_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
